alu_mdu_decoder: RTL and testbench

Parametrised successor to the single-cycle ALU control decoder. It decodes ALUOp/Funct into a 4-bit ALU control word covering the extended R-type set. It also owns the HI/LO registers and an iterative multiply/divide sequencer that stalls the datapath while MULT/MULTU/DIV/DIVU run. It sits beside the main ALU in the execute path and feeds the writeback mux on MFHI/MFLO.

---
 rtl/alu_mdu_decoder_if.sv | 29 ++
 rtl/alu_mdu_decoder.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_mdu_decoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_decoder_if.sv
// Execute-stage bus between the datapath and the ALU-control / mul-div unit.
// master: datapath side (drives instruction fields and operands).
// slave : alu_mdu_decoder (returns ALU control, stall and HI/LO readback).
// Parameters: W = operand and HI/LO width, CW = ALUControl width.
interface alu_mdu_decoder_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 4
);
  logic          InstrValid;
  logic [1:0]    ALUOp;
  logic [5:0]    Funct;
  logic [W-1:0]  SrcA;
  logic [W-1:0]  SrcB;
  logic [CW-1:0] ALUControl;
  logic          Illegal;
  logic          Stall;
  logic          HiLoSel;
  logic [W-1:0]  HiLoOut;

  modport master (
    output InstrValid, ALUOp, Funct, SrcA, SrcB,
    input  ALUControl, Illegal, Stall, HiLoSel, HiLoOut
  );

  modport slave (
    input  InstrValid, ALUOp, Funct, SrcA, SrcB,
    output ALUControl, Illegal, Stall, HiLoSel, HiLoOut
  );
endinterface

// File: rtl/alu_mdu_decoder.sv
// ALU control decoder with HI/LO registers and an iterative mul/div sequencer.
// Ports:
//   clk    - system clock
//   rst_n  - synchronous active-low reset
//   bus    - alu_mdu_decoder_if.slave: InstrValid/ALUOp/Funct/SrcA/SrcB in,
//            ALUControl/Illegal/Stall/HiLoSel/HiLoOut out (combinational)
// Macro MDU_DIV_EN: when defined, DIV/DIVU run on a restoring divider;
// when undefined the divider is absent and DIV/DIVU decode as illegal.
module alu_mdu_decoder #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_mdu_decoder_if.slave bus
);

  localparam int unsigned CNTW = $clog2(W);
  localparam int unsigned PW   = 2 * W;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic [W-1:0]    r_acc_hi;
  logic [W-1:0]    r_acc_lo;
  logic [W-1:0]    r_opd;
  logic            r_neg_lo;
`ifdef MDU_DIV_EN
  logic            r_is_div;
  logic            r_neg_hi;
`endif

  logic [3:0]      w_alu_ctl;
  logic            w_illegal;
  logic            w_mul;
  logic            w_div;
  logic            w_sgn;
  logic            w_mfhi;
  logic            w_mflo;
  logic            w_mthi;
  logic            w_mtlo;
  logic            w_stall;
  logic            w_start;
  logic            w_hilo_rd;
  logic            w_last;
  logic            w_sa;
  logic            w_sb;
  logic [W-1:0]    w_abs_a;
  logic [W-1:0]    w_abs_b;
  logic [W:0]      w_add;
  logic [W-1:0]    w_step_hi;
  logic [W-1:0]    w_step_lo;
  logic [PW-1:0]   w_prod;
  logic [PW-1:0]   w_prod_fix;
  logic [W-1:0]    w_fix_hi;
  logic [W-1:0]    w_fix_lo;
`ifdef MDU_DIV_EN
  logic [W:0]      w_shift;
  logic [W+1:0]    w_diff;
  logic [W-1:0]    w_quo_fix;
  logic [W-1:0]    w_rem_fix;
`endif

  // Instruction decode: ALU control word plus HI/LO and mul/div op flags.
  always_comb begin
    w_alu_ctl = 4'b0010;
    w_illegal = 1'b0;
    w_mul     = 1'b0;
    w_div     = 1'b0;
    w_sgn     = 1'b0;
    w_mfhi    = 1'b0;
    w_mflo    = 1'b0;
    w_mthi    = 1'b0;
    w_mtlo    = 1'b0;
    case (bus.ALUOp)
      2'b00: w_alu_ctl = 4'b0010;
      2'b01: w_alu_ctl = 4'b0110;
      2'b10: begin
        case (bus.Funct)
          6'b100000: w_alu_ctl = 4'b0010;
          6'b100010: w_alu_ctl = 4'b0110;
          6'b100100: w_alu_ctl = 4'b0000;
          6'b100101: w_alu_ctl = 4'b0001;
          6'b100110: w_alu_ctl = 4'b0011;
          6'b100111: w_alu_ctl = 4'b0100;
          6'b101010: w_alu_ctl = 4'b0111;
          6'b101011: w_alu_ctl = 4'b0101;
          6'b010000: w_mfhi = 1'b1;
          6'b010001: w_mthi = 1'b1;
          6'b010010: w_mflo = 1'b1;
          6'b010011: w_mtlo = 1'b1;
          6'b011000: begin w_mul = 1'b1; w_sgn = 1'b1; end
          6'b011001: w_mul = 1'b1;
`ifdef MDU_DIV_EN
          6'b011010: begin w_div = 1'b1; w_sgn = 1'b1; end
          6'b011011: w_div = 1'b1;
`endif
          default: begin w_alu_ctl = 4'b0000; w_illegal = 1'b1; end
        endcase
      end
      default: begin w_alu_ctl = 4'b0000; w_illegal = 1'b1; end
    endcase
  end

  // Operand magnitudes for the signed ops; signs are reapplied at the end.
  always_comb begin
    w_sa    = w_sgn & bus.SrcA[W-1];
    w_sb    = w_sgn & bus.SrcB[W-1];
    w_abs_a = w_sa ? (~bus.SrcA + W'(1)) : bus.SrcA;
    w_abs_b = w_sb ? (~bus.SrcB + W'(1)) : bus.SrcB;
  end

  // One iteration: shift-add multiply (acc_lo holds multiplier) or restoring
  // divide (acc_lo holds dividend shifting out / quotient shifting in).
  always_comb begin
    w_add     = r_acc_lo[0] ? ({1'b0, r_acc_hi} + {1'b0, r_opd}) : {1'b0, r_acc_hi};
    w_step_hi = w_add[W:1];
    w_step_lo = {w_add[0], r_acc_lo[W-1:1]};
`ifdef MDU_DIV_EN
    w_shift = {r_acc_hi, r_acc_lo[W-1]};
    w_diff  = {1'b0, w_shift} - {2'b00, r_opd};
    if (r_is_div) begin
      // Divisor 0 never borrows: quotient all ones, remainder = dividend.
      w_step_hi = w_diff[W+1] ? w_shift[W-1:0] : w_diff[W-1:0];
      w_step_lo = {r_acc_lo[W-2:0], ~w_diff[W+1]};
    end
`endif
  end

  // Sign fix-up of the final iteration's result, written to HI/LO on entry to DONE.
  always_comb begin
    w_prod     = {w_step_hi, w_step_lo};
    w_prod_fix = r_neg_lo ? (~w_prod + PW'(1)) : w_prod;
    w_fix_hi   = w_prod_fix[PW-1:W];
    w_fix_lo   = w_prod_fix[W-1:0];
`ifdef MDU_DIV_EN
    w_quo_fix = r_neg_lo ? (~w_step_lo + W'(1)) : w_step_lo;
    w_rem_fix = r_neg_hi ? (~w_step_hi + W'(1)) : w_step_hi;
    if (r_is_div) begin
      w_fix_hi = w_rem_fix;
      w_fix_lo = w_quo_fix;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and sequencer control.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_start     = 1'b0;
    w_hilo_rd   = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_hilo_rd = 1'b1;
        if (bus.InstrValid && (w_mul || w_div)) begin
          w_start     = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == CNTW'(W - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Held mul/div instruction retires here; it must not restart.
        w_hilo_rd   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: operand latch, iteration, HI/LO update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opd    <= '0;
      r_neg_lo <= 1'b0;
`ifdef MDU_DIV_EN
      r_is_div <= 1'b0;
      r_neg_hi <= 1'b0;
`endif
    end else if (w_start) begin
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= w_abs_b;
      r_opd    <= w_abs_a;
      r_neg_lo <= w_sa ^ w_sb;
`ifdef MDU_DIV_EN
      r_is_div <= w_div;
      r_neg_hi <= w_sa;
      if (w_div) begin
        r_acc_lo <= w_abs_a;
        r_opd    <= w_abs_b;
      end
`endif
    end else if (r_state == S_BUSY) begin
      r_cnt    <= r_cnt + CNTW'(1);
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
      if (w_last) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
    end else if (r_state == S_IDLE && bus.InstrValid) begin
      if (w_mthi) r_hi <= bus.SrcA;
      if (w_mtlo) r_lo <= bus.SrcA;
    end
  end

  // Outputs.
  always_comb begin
    bus.ALUControl = CW'(w_alu_ctl);
    bus.Illegal    = bus.InstrValid & w_illegal;
    bus.Stall      = w_stall;
    bus.HiLoSel    = bus.InstrValid & w_hilo_rd & (w_mfhi | w_mflo);
    bus.HiLoOut    = '0;
    if (bus.HiLoSel) bus.HiLoOut = w_mfhi ? r_hi : r_lo;
  end

endmodule

// File: tb/tb_alu_mdu_decoder.sv
// Directed self-checking bench for alu_mdu_decoder (W=32, CW=4).
module tb_alu_mdu_decoder;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_mdu_decoder_if #(.W(W), .CW(CW)) bus ();
  alu_mdu_decoder #(.W(W), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.InstrValid = 1'b1;
    bus.ALUOp      = op;
    bus.Funct      = f;
    bus.SrcA       = a;
    bus.SrcB       = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // MFHI then MFLO; each must select HI/LO and not stall.
  task automatic read_hilo(input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    drive(2'b10, F_MFHI, '0, '0);
    @(negedge clk);
    check({tag, " mfhi sel"}, 64'(bus.HiLoSel), 64'(1));
    check({tag, " mfhi stall"}, 64'(bus.Stall), 64'(0));
    check({tag, " HI"}, 64'(bus.HiLoOut), 64'(exp_hi));
    next_cycle();
    drive(2'b10, F_MFLO, '0, '0);
    @(negedge clk);
    check({tag, " LO"}, 64'(bus.HiLoOut), 64'(exp_lo));
    next_cycle();
    bus.InstrValid = 1'b0;
  endtask

  // Issue a mul/div, hold it while stalled, count stall cycles, then read HI/LO.
  task automatic run_mdu(input string tag, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    drive(2'b10, f, a, b);
    #1;
    check({tag, " ctl"}, 64'(bus.ALUControl), 64'(4'b0010));
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.Stall) begin
        cyc++;
        next_cycle();
      end else begin
        done = 1'b1;
      end
    end
    check({tag, " completed"}, 64'(done), 64'(1));
    check({tag, " stall cycles"}, 64'(cyc), 64'(W + 1));
    next_cycle();
    bus.InstrValid = 1'b0;
    read_hilo(tag, exp_hi, exp_lo);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] ctl;
    logic       ill;
  } dec_t;

  dec_t vec [12];

  initial begin
    vec = '{
      '{2'b00, 6'b000000, 4'b0010, 1'b0},
      '{2'b01, 6'b000000, 4'b0110, 1'b0},
      '{2'b10, 6'b100000, 4'b0010, 1'b0},
      '{2'b10, 6'b100010, 4'b0110, 1'b0},
      '{2'b10, 6'b100100, 4'b0000, 1'b0},
      '{2'b10, 6'b100101, 4'b0001, 1'b0},
      '{2'b10, 6'b100110, 4'b0011, 1'b0},
      '{2'b10, 6'b100111, 4'b0100, 1'b0},
      '{2'b10, 6'b101010, 4'b0111, 1'b0},
      '{2'b10, 6'b101011, 4'b0101, 1'b0},
      '{2'b11, 6'b100000, 4'b0000, 1'b1},
      '{2'b10, 6'b000111, 4'b0000, 1'b1}
    };

    rst_n = 1'b0;
    drive(2'b00, 6'b000000, '0, '0);
    bus.InstrValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst stall", 64'(bus.Stall), 64'(0));
    check("rst hilosel", 64'(bus.HiLoSel), 64'(0));
    check("rst hilout", 64'(bus.HiLoOut), 64'(0));
    check("rst illegal", 64'(bus.Illegal), 64'(0));
    check("rst ctl", 64'(bus.ALUControl), 64'(4'b0010));
    next_cycle();
    read_hilo("rst", 32'h0, 32'h0);

    // Decode sweep.
    for (int i = 0; i < 12; i++) begin
      drive(vec[i].op, vec[i].f, '0, '0);
      @(negedge clk);
      check($sformatf("dec%0d ctl", i), 64'(bus.ALUControl), 64'(vec[i].ctl));
      check($sformatf("dec%0d ill", i), 64'(bus.Illegal), 64'(vec[i].ill));
      check($sformatf("dec%0d stall", i), 64'(bus.Stall), 64'(0));
      next_cycle();
    end
    drive(2'b10, 6'b000111, '0, '0);
    bus.InstrValid = 1'b0;
    @(negedge clk);
    check("ill gated", 64'(bus.Illegal), 64'(0));
    next_cycle();

    // Multiply.
    run_mdu("mult", F_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_mdu("multu", F_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);

`ifdef MDU_DIV_EN
    run_mdu("divu7/2", F_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    run_mdu("div-7/2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_mdu("div min/-1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_mdu("divu5/0", F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
`else
    drive(2'b10, F_DIVU, 32'd5, 32'd0);
    @(negedge clk);
    check("divu off ill", 64'(bus.Illegal), 64'(1));
    check("divu off ctl", 64'(bus.ALUControl), 64'(4'b0000));
    check("divu off stall", 64'(bus.Stall), 64'(0));
    next_cycle();
    drive(2'b10, F_DIV, 32'd7, 32'd2);
    @(negedge clk);
    check("div off ill", 64'(bus.Illegal), 64'(1));
    check("div off stall", 64'(bus.Stall), 64'(0));
    next_cycle();
    bus.InstrValid = 1'b0;
    read_hilo("div off", 32'h0000_0002, 32'hFFFF_FFFA);
`endif

    // Move to / from HI and LO.
    drive(2'b10, F_MTHI, 32'h0000_1234, '0);
    @(negedge clk);
    check("mthi stall", 64'(bus.Stall), 64'(0));
    next_cycle();
    drive(2'b10, F_MTLO, 32'h0000_ABCD, '0);
    @(negedge clk);
    check("mtlo stall", 64'(bus.Stall), 64'(0));
    next_cycle();
    bus.InstrValid = 1'b0;
    read_hilo("mt", 32'h0000_1234, 32'h0000_ABCD);

    // Reset in the 10th BUSY cycle of a MULT.
    drive(2'b10, F_MULT, 32'hFFFF_FFFE, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    check("abort busy stall", 64'(bus.Stall), 64'(1));
    rst_n = 1'b0;
    bus.InstrValid = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort stall", 64'(bus.Stall), 64'(0));
    next_cycle();
    read_hilo("abort", 32'h0, 32'h0);
    run_mdu("multu3*4", F_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
